writeback_stage: RTL and testbench
==================================

# writeback_stage

Final (MEM/WB → WB) stage of the RISC-V pipeline, sitting directly upstream of the register file. It selects the writeback value and sign/zero-extends load data, handling a variable-latency data-memory response. It drives the register file's write port (`writeEn`, `address_wr`, `write_data`) from posedge-registered outputs, so the register file's negedge write sees stable values half a cycle later. It also stalls the upstream pipeline while a load is outstanding.

## Interface
- `TIMEOUT`, default 64: load-wait cycle limit. Used only with `WB_LOAD_TIMEOUT_EN`. Range 2..255.

- `clock` in 1: pipeline clock, posedge-sampled.
- `reset` in 1: asynchronous, active-low. Low forces reset state immediately.
- `in_valid` in 1: an instruction is present on `in_*`.
- `in_regWrite` in 1: the instruction writes `rd`.
- `in_rd` in 5: destination register.
- `in_resultSrc` in 2: writeback source. 00 ALU, 01 load, 10 PC+4, 11 immediate.
- `in_aluResult` in 32: ALU result or load address. Bits [1:0] give the byte offset.
- `in_pcPlus4` in 32: link value.
- `in_imm` in 32: LUI immediate.
- `in_funct3` in 3: load type.
- `dmem_rvalid` in 1: load data valid this cycle.
- `dmem_rdata` in 32: raw aligned memory word.
- `stall` out 1: upstream must hold `in_*` and not advance.
- `writeEn` out 1: register-file write enable.
- `address_wr` out 5: register-file write address.
- `write_data` out 32: register-file write data.
- `load_err` out 1: load timeout pulse. Constant 0 without the macro.

## Operation
- States: IDLE, WAIT.
- `stall` = (state == WAIT). It is combinational from state only.
- In IDLE, with `in_valid` = 1 and `in_resultSrc` ≠ 01, the next posedge registers:
  - `writeEn` = `in_regWrite` & (`in_rd` ≠ 0)
  - `address_wr` = `in_rd`
  - `write_data` = mux(`in_resultSrc`)
- In IDLE, with `in_valid` = 1 and `in_resultSrc` = 01, the next posedge:
  - captures `in_regWrite`, `in_rd`, `in_funct3`, `in_aluResult[1:0]`;
  - moves to WAIT;
  - sets `writeEn` = 0.
- In IDLE with `in_valid` = 0: `writeEn` = 0. `address_wr` and `write_data` hold.
- `dmem_rvalid` is ignored in IDLE.
- In WAIT, `in_*` is ignored; upstream holds the next instruction via `stall`.
- On a posedge in WAIT with `dmem_rvalid` = 1:
  - registers the extended load value;
  - `writeEn` = captured regWrite & (captured rd ≠ 0);
  - moves to IDLE.
- The held instruction is consumed on the following posedge. Back-to-back instructions therefore never collide.
- Load extension (offset = captured bits [1:0]):
  - 000 LB: byte[offset], sign-extended.
  - 001 LH: halfword[offset[1]], sign-extended. offset[0] is ignored.
  - 010 LW: full word.
  - 100 LBU: byte[offset], zero-extended.
  - 101 LHU: halfword[offset[1]], zero-extended.
  - Any other funct3: treated as LW.
- Writes to x0 never assert `writeEn`.

## Timing
- Reset values: state IDLE, `stall` 0, `writeEn` 0, `address_wr` 0, `write_data` 0, `load_err` 0, timeout counter 0.
- Non-load latency: 1 posedge from `in_valid` to `writeEn`. The register file commits at the following negedge.
- Load latency: 1 posedge to enter WAIT, plus N ≥ 1 cycles until `dmem_rvalid`. `writeEn` is a 1-cycle pulse after the rvalid posedge.
- `writeEn` is never high for more than one cycle per instruction.
- `reset` asserted mid-WAIT: the pending load is discarded, `stall` drops immediately, and no write occurs.

## Configuration
- `WB_LOAD_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without `dmem_rvalid`.
  - When the counter reaches `TIMEOUT` − 1 without rvalid, the next posedge:
    - returns to IDLE;
    - keeps `writeEn` = 0 (the load is dropped);
    - pulses `load_err` = 1 for exactly one cycle.
  - If rvalid arrives on the same cycle as the limit, rvalid wins: normal write, no error.
- Not defined: WAIT persists indefinitely, `load_err` is tied 0, and `TIMEOUT` is unused.

## Test plan
- Reset release, then ALU op with rd=5, aluResult=0x1234 → next cycle `writeEn`=1, `address_wr`=5, `write_data`=0x1234. Following idle cycle → `writeEn`=0.
- JAL-type op, resultSrc=10, pcPlus4=0x40, rd=1 → `write_data`=0x40. LUI op, resultSrc=11, imm=0xABCD0000, rd=0 → `writeEn`=0.
- LB at offset 2, rdata=0x00800000 → `stall`=1 for 3 cycles, `dmem_rvalid` on the 3rd WAIT cycle → `write_data`=0xFFFFFF80. LBU same case → 0x00000080. LH at offset 2, rdata=0x80010000 → 0xFFFF8001.
- Load followed immediately by ALU op rd=7 → ALU op held during WAIT; its write occurs exactly one cycle after the load's write; no lost or duplicated `writeEn` pulses.
- `reset` pulled low in WAIT → `stall`=0 and `writeEn`=0 immediately. A later `dmem_rvalid` in IDLE → no write.
- With `WB_LOAD_TIMEOUT_EN`, TIMEOUT=4, no rvalid → `load_err` pulses once after the 4th WAIT cycle, with `writeEn`=0 and state IDLE. Rvalid on the limit cycle → normal write and `load_err`=0.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage feeding the register-file write port.
// Selects the writeback value, sign/zero-extends load data, and stalls the
// upstream pipeline while a load response is outstanding.
// Optional feature macro: WB_LOAD_TIMEOUT_EN (drops a load after TIMEOUT
// wait cycles and pulses load_err).
module writeback_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_regWrite,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_resultSrc,
    input  logic [31:0] in_aluResult,
    input  logic [31:0] in_pcPlus4,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_funct3,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        writeEn,
    output logic [4:0]  address_wr,
    output logic [31:0] write_data,
    output logic        load_err
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;

    logic        r_state;
    logic        r_ld_regWrite;
    logic [4:0]  r_ld_rd;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_off;
    logic        r_writeEn;
    logic [4:0]  r_address_wr;
    logic [31:0] r_write_data;

    logic [31:0] w_nonload_data;
    logic [31:0] w_load_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_timeout;

    assign stall      = (r_state == S_WAIT);
    assign writeEn    = r_writeEn;
    assign address_wr = r_address_wr;
    assign write_data = r_write_data;

    // Writeback source mux for non-load instructions (01 never reaches here).
    always_comb begin
        w_nonload_data = in_aluResult;
        case (in_resultSrc)
            2'b10:   w_nonload_data = in_pcPlus4;
            2'b11:   w_nonload_data = in_imm;
            default: w_nonload_data = in_aluResult;
        endcase
    end

    // Lane select and extension of the raw memory word using the captured offset.
    always_comb begin
        case (r_ld_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_ld_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

`ifdef WB_LOAD_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_load_err;

    assign w_timeout = (r_state == S_WAIT) && !dmem_rvalid && (r_cnt == 8'(TIMEOUT - 1));
    assign load_err  = r_load_err;

    // Wait-cycle counter (held at 0 outside WAIT) and one-cycle error pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt      <= 8'd0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= w_timeout;
            if (r_state == S_IDLE)
                r_cnt <= 8'd0;
            else if (!dmem_rvalid)
                r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
    assign load_err         = 1'b0;
`endif

    // Stage state, captured load context and registered write-port outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_ld_regWrite <= 1'b0;
            r_ld_rd       <= 5'd0;
            r_ld_funct3   <= 3'd0;
            r_ld_off      <= 2'd0;
            r_writeEn     <= 1'b0;
            r_address_wr  <= 5'd0;
            r_write_data  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_resultSrc == 2'b01) begin
                            r_ld_regWrite <= in_regWrite;
                            r_ld_rd       <= in_rd;
                            r_ld_funct3   <= in_funct3;
                            r_ld_off      <= in_aluResult[1:0];
                            r_writeEn     <= 1'b0;
                            r_state       <= S_WAIT;
                        end else begin
                            r_writeEn    <= in_regWrite && (in_rd != 5'd0);
                            r_address_wr <= in_rd;
                            r_write_data <= w_nonload_data;
                        end
                    end else begin
                        r_writeEn <= 1'b0;
                    end
                end
                default: begin
                    if (dmem_rvalid) begin
                        r_writeEn    <= r_ld_regWrite && (r_ld_rd != 5'd0);
                        r_address_wr <= r_ld_rd;
                        r_write_data <= w_load_data;
                        r_state      <= S_IDLE;
                    end else begin
                        r_writeEn <= 1'b0;
                        if (w_timeout)
                            r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vectors with literal expectations plus
// a behavioural model compared against the DUT on every negedge.
module tb_writeback_stage;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_regWrite = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [1:0]  in_resultSrc = '0;
    logic [31:0] in_aluResult = '0;
    logic [31:0] in_pcPlus4 = '0;
    logic [31:0] in_imm = '0;
    logic [2:0]  in_funct3 = '0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall;
    logic        writeEn;
    logic [4:0]  address_wr;
    logic [31:0] write_data;
    logic        load_err;

    int total = 0;
    int bad = 0;
    int dut_pulses = 0;
    int exp_pulses = 0;

    writeback_stage #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_regWrite(in_regWrite),
        .in_rd(in_rd), .in_resultSrc(in_resultSrc), .in_aluResult(in_aluResult),
        .in_pcPlus4(in_pcPlus4), .in_imm(in_imm), .in_funct3(in_funct3),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall(stall),
        .writeEn(writeEn), .address_wr(address_wr), .write_data(write_data),
        .load_err(load_err)
    );

    always #5 clock = ~clock;

    // Behavioural model: a "load outstanding" flag plus the expected write port.
    logic        m_busy, m_we, m_err, m_ldwe;
    logic [4:0]  m_addr, m_ldrd;
    logic [31:0] m_data;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    int          m_waited;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
        logic [31:0] v;
        if (f3 == 3'b000 || f3 == 3'b100) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (f3 == 3'b000 && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
            v = (word >> (16 * (off / 2))) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 0; m_we <= 0; m_err <= 0; m_addr <= 0; m_data <= 0;
            m_ldwe <= 0; m_ldrd <= 0; m_f3 <= 0; m_off <= 0; m_waited <= 0;
        end else begin
            m_err <= 0;
            if (!m_busy) begin
                m_we <= 0;
                if (in_valid && in_resultSrc == 2'b01) begin
                    m_busy <= 1; m_ldwe <= in_regWrite; m_ldrd <= in_rd;
                    m_f3 <= in_funct3; m_off <= in_aluResult % 4; m_waited <= 0;
                end else if (in_valid) begin
                    m_we   <= in_regWrite && in_rd != 0;
                    m_addr <= in_rd;
                    m_data <= (in_resultSrc == 2'b10) ? in_pcPlus4 :
                              (in_resultSrc == 2'b11) ? in_imm : in_aluResult;
                end
            end else if (dmem_rvalid) begin
                m_busy <= 0;
                m_we   <= m_ldwe && m_ldrd != 0;
                m_addr <= m_ldrd;
                m_data <= extend(m_f3, m_off, dmem_rdata);
            end else begin
                m_we <= 0;
                m_waited <= m_waited + 1;
`ifdef WB_LOAD_TIMEOUT_EN
                if (m_waited + 1 == TO) begin
                    m_busy <= 0;
                    m_err  <= 1;
                end
`endif
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (reset) begin
            total += 5;
            if (stall !== m_busy) begin bad++; $display("FAIL cmp_stall got=%0b want=%0b t=%0t", stall, m_busy, $time); end
            if (writeEn !== m_we) begin bad++; $display("FAIL cmp_writeEn got=%0b want=%0b t=%0t", writeEn, m_we, $time); end
            if (address_wr !== m_addr) begin bad++; $display("FAIL cmp_addr got=%0d want=%0d t=%0t", address_wr, m_addr, $time); end
            if (write_data !== m_data) begin bad++; $display("FAIL cmp_data got=%h want=%h t=%0t", write_data, m_data, $time); end
            if (load_err !== m_err) begin bad++; $display("FAIL cmp_load_err got=%0b want=%0b t=%0t", load_err, m_err, $time); end
            if (writeEn === 1'b1) dut_pulses++;
            if (m_we) exp_pulses++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic set_op(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [2:0] f3);
        in_valid = 1; in_regWrite = 1; in_resultSrc = src; in_rd = rd;
        in_aluResult = alu; in_funct3 = f3;
    endtask

    // Issue a load, then assert rvalid on the n-th WAIT cycle.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] word, input int n);
        set_op(2'b01, rd, addr, f3);
        step();
        in_valid = 0;
        for (int k = 1; k <= n; k++) begin
            check("stall_in_wait", {31'd0, stall}, 32'd1);
            if (k == n) begin dmem_rvalid = 1; dmem_rdata = word; end
            step();
        end
        dmem_rvalid = 0;
    endtask

    initial begin
        step(); step();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_writeEn", {31'd0, writeEn}, 32'd0);
        check("rst_addr", {27'd0, address_wr}, 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        reset = 1;

        set_op(2'b00, 5'd5, 32'h1234, 3'd0); step();
        check("alu_we", {31'd0, writeEn}, 32'd1);
        check("alu_addr", {27'd0, address_wr}, 32'd5);
        check("alu_data", write_data, 32'h1234);
        in_valid = 0; step();
        check("idle_we", {31'd0, writeEn}, 32'd0);
        check("idle_hold", write_data, 32'h1234);

        set_op(2'b10, 5'd1, 32'h0, 3'd0); in_pcPlus4 = 32'h40; step();
        check("jal_data", write_data, 32'h40);
        set_op(2'b11, 5'd0, 32'h0, 3'd0); in_imm = 32'hABCD0000; step();
        check("lui_x0_we", {31'd0, writeEn}, 32'd0);
        in_valid = 0;

        do_load(3'b000, 32'h102, 5'd10, 32'h00800000, 3);
        check("lb_data", write_data, 32'hFFFFFF80);
        check("lb_we", {31'd0, writeEn}, 32'd1);
        check("lb_stall", {31'd0, stall}, 32'd0);
        step();
        check("lb_we_fall", {31'd0, writeEn}, 32'd0);
        do_load(3'b100, 32'h102, 5'd10, 32'h00800000, 3);
        check("lbu_data", write_data, 32'h00000080);
        do_load(3'b001, 32'h102, 5'd11, 32'h80010000, 1);
        check("lh_data", write_data, 32'hFFFF8001);
        do_load(3'b101, 32'h101, 5'd12, 32'h1234ABCD, 2);
        check("lhu_off1_data", write_data, 32'h0000ABCD);
        do_load(3'b011, 32'h103, 5'd13, 32'hDEADBEEF, 6);
        check("f3_011_as_lw", write_data, 32'hDEADBEEF);
        do_load(3'b000, 32'h103, 5'd0, 32'hF0000000, 1);
        check("load_x0_we", {31'd0, writeEn}, 32'd0);
        step();

        // load immediately followed by an ALU op held by stall
        set_op(2'b01, 5'd8, 32'h200, 3'b010); step();
        set_op(2'b00, 5'd7, 32'h77, 3'd0);
        check("b2b_stall", {31'd0, stall}, 32'd1);
        step();
        dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D; step();
        dmem_rvalid = 0;
        check("b2b_load_addr", {27'd0, address_wr}, 32'd8);
        check("b2b_load_data", write_data, 32'hCAFEF00D);
        step();
        check("b2b_alu_we", {31'd0, writeEn}, 32'd1);
        check("b2b_alu_addr", {27'd0, address_wr}, 32'd7);
        in_valid = 0; step();
        check("b2b_after_we", {31'd0, writeEn}, 32'd0);

        // reset during WAIT discards the load
        set_op(2'b01, 5'd9, 32'h300, 3'b010); step();
        in_valid = 0;
        check("rw_stall_before", {31'd0, stall}, 32'd1);
        reset = 0; #1;
        check("rw_stall_async", {31'd0, stall}, 32'd0);
        check("rw_we_async", {31'd0, writeEn}, 32'd0);
        step(); reset = 1;
        dmem_rvalid = 1; dmem_rdata = 32'h55; step();
        dmem_rvalid = 0;
        check("rvalid_idle_no_we", {31'd0, writeEn}, 32'd0);
        check("rvalid_idle_no_stall", {31'd0, stall}, 32'd0);

`ifdef WB_LOAD_TIMEOUT_EN
        set_op(2'b01, 5'd11, 32'h400, 3'b010); step();
        in_valid = 0;
        for (int k = 1; k <= TO; k++) begin
            check("to_stall", {31'd0, stall}, 32'd1);
            step();
        end
        check("to_err", {31'd0, load_err}, 32'd1);
        check("to_we", {31'd0, writeEn}, 32'd0);
        check("to_idle", {31'd0, stall}, 32'd0);
        step();
        check("to_err_pulse", {31'd0, load_err}, 32'd0);
        do_load(3'b010, 32'h500, 5'd12, 32'h1111, TO);
        check("limit_we", {31'd0, writeEn}, 32'd1);
        check("limit_err", {31'd0, load_err}, 32'd0);
        check("limit_data", write_data, 32'h1111);
`endif

        step(); step();
        check("pulse_count", dut_pulses, exp_pulses);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
